// File: rtl/alu_arb_pkg.sv
`default_nettype none
// alu_arb_pkg: shared types and constants for the ALU arbiter/sequencer.
// Rev 1.0
package alu_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

   // Control word layout: {sel[6:5], shift[4:3], arith[2], logic[1:0]}
   localparam int OP_W         = 7;
   localparam int OP_SEL_LSB   = 5;
   localparam int OP_SHIFT_LSB = 3;
   localparam int OP_ARITH_BIT = 2;
   localparam int OP_LOGIC_LSB = 0;

   localparam logic [1:0] SEL_SHIFT = 2'd0;
   localparam logic [1:0] SEL_SLT   = 2'd1;
   localparam logic [1:0] SEL_ARITH = 2'd2;
   localparam logic [1:0] SEL_LOGIC = 2'd3;

   localparam logic ARITH_ADD = 1'b0;
   localparam logic ARITH_SUB = 1'b1;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// rr_arbiter2: two-way round-robin grant; a tie goes to the requester not served last.
// Rev 1.0
module rr_arbiter2 (
   input  logic [1:0] i_valid,
   input  logic       i_rr_last,
   output logic [1:0] o_grant
);

   always_comb begin
      o_grant = i_valid;
      if (&i_valid) begin
         o_grant = i_rr_last ? 2'b01 : 2'b10;
      end
   end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// alu_arbiter: round-robin sequencer sharing one execute ALU between two requesters.
// Rev 1.0
module alu_arbiter
   import alu_arb_pkg::*;
#(
   parameter int W   = 32,
   parameter int SAW = 5
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [1:0]       i_req_valid,
   output logic [1:0]       o_req_ready,
   input  logic [W-1:0]     i_req_a0,
   input  logic [W-1:0]     i_req_a1,
   input  logic [W-1:0]     i_req_b0,
   input  logic [W-1:0]     i_req_b1,
   input  logic [SAW-1:0]   i_req_sa0,
   input  logic [SAW-1:0]   i_req_sa1,
   input  logic [OP_W-1:0]  i_req_op0,
   input  logic [OP_W-1:0]  i_req_op1,
   output logic [W-1:0]     o_alu_a,
   output logic [W-1:0]     o_alu_b,
   output logic [SAW-1:0]   o_alu_sa,
   output logic [1:0]       o_alu_shiftop,
   output logic             o_alu_arithop,
   output logic [1:0]       o_alu_logicop,
   output logic [1:0]       o_alu_sel,
   input  logic [W-1:0]     i_alu_out,
   input  logic             i_alu_zero,
   output logic [1:0]       o_rsp_valid,
   input  logic [1:0]       i_rsp_ready,
   output logic [W-1:0]     o_rsp_data,
   output logic             o_rsp_zero
);

   state_e            state_q, state_d;
   logic              rr_last_q, rr_last_d;
   logic              gnt_q, gnt_d;
   logic [1:0]        w_grant;
   logic              w_load;
   logic              w_capture;

   logic [W-1:0]      a_q, b_q;
   logic [SAW-1:0]    sa_q;
   logic [OP_W-1:0]   op_q;
   logic [W-1:0]      rsp_data_q;
   logic              rsp_zero_q;

   rr_arbiter2 u_rr (
      .i_valid   (i_req_valid),
      .i_rr_last (rr_last_q),
      .o_grant   (w_grant)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= IDLE;
         rr_last_q <= 1'b1;
         gnt_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         rr_last_q <= rr_last_d;
         gnt_q     <= gnt_d;
      end
   end

   // Ready is masked by reset so a held request is never acknowledged while in reset.
   always_comb begin
      state_d     = state_q;
      rr_last_d   = rr_last_q;
      gnt_d       = gnt_q;
      o_req_ready = 2'b00;
      o_rsp_valid = 2'b00;
      w_load      = 1'b0;
      w_capture   = 1'b0;
      case (state_q)
         IDLE: begin
            if (|w_grant) begin
               o_req_ready = w_grant & {2{i_rst_n}};
               w_load      = 1'b1;
               gnt_d       = w_grant[1];
               state_d     = EXEC;
            end
         end
         EXEC: begin
            w_capture = 1'b1;
            state_d   = RESP;
         end
         RESP: begin
            o_rsp_valid[gnt_q] = 1'b1;
            if (i_rsp_ready[gnt_q]) begin
               rr_last_d = gnt_q;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         a_q        <= '0;
         b_q        <= '0;
         sa_q       <= '0;
         op_q       <= '0;
         rsp_data_q <= '0;
         rsp_zero_q <= 1'b0;
      end else begin
         if (w_load) begin
            a_q  <= w_grant[1] ? i_req_a1  : i_req_a0;
            b_q  <= w_grant[1] ? i_req_b1  : i_req_b0;
            sa_q <= w_grant[1] ? i_req_sa1 : i_req_sa0;
            op_q <= w_grant[1] ? i_req_op1 : i_req_op0;
         end
         if (w_capture) begin
            rsp_data_q <= i_alu_out;
            rsp_zero_q <= i_alu_zero;
         end
      end
   end

   assign o_alu_a       = a_q;
   assign o_alu_b       = b_q;
   assign o_alu_sa      = sa_q;
   assign o_alu_sel     = op_q[OP_SEL_LSB +: 2];
   assign o_alu_shiftop = op_q[OP_SHIFT_LSB +: 2];
   assign o_alu_arithop = op_q[OP_ARITH_BIT];
   assign o_alu_logicop = op_q[OP_LOGIC_LSB +: 2];
   assign o_rsp_data    = rsp_data_q;
   assign o_rsp_zero    = rsp_zero_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// tb_alu_arbiter: directed self-checking bench with a behavioural ALU on the drive bus.
// Rev 1.0
module tb_alu_arbiter;
   import alu_arb_pkg::*;

   localparam int W   = 32;
   localparam int SAW = 5;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [1:0]      req_valid, req_ready, rsp_valid, rsp_ready;
   logic [W-1:0]    a0, a1, b0, b1, alu_a, alu_b, alu_out, rsp_data;
   logic [SAW-1:0]  sa0, sa1, alu_sa;
   logic [6:0]      op0, op1;
   logic [1:0]      alu_shiftop, alu_logicop, alu_sel;
   logic            alu_arithop, alu_zero, rsp_zero;
   int              checks = 0;
   int              errors = 0;

   always #5 clk = ~clk;

   alu_arbiter #(.W(W), .SAW(SAW)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_req_valid(req_valid), .o_req_ready(req_ready),
      .i_req_a0(a0), .i_req_a1(a1), .i_req_b0(b0), .i_req_b1(b1),
      .i_req_sa0(sa0), .i_req_sa1(sa1), .i_req_op0(op0), .i_req_op1(op1),
      .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_sa(alu_sa),
      .o_alu_shiftop(alu_shiftop), .o_alu_arithop(alu_arithop),
      .o_alu_logicop(alu_logicop), .o_alu_sel(alu_sel),
      .i_alu_out(alu_out), .i_alu_zero(alu_zero),
      .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
      .o_rsp_data(rsp_data), .o_rsp_zero(rsp_zero)
   );

   // Shared ALU: shift 0=sll 1=srl else sra; logic 0=and 1=or 2=xor 3=nor.
   always_comb begin
      alu_out = '0;
      case (alu_sel)
         SEL_SHIFT: begin
            case (alu_shiftop)
               2'd0:    alu_out = alu_b << alu_sa;
               2'd1:    alu_out = alu_b >> alu_sa;
               default: alu_out = $signed(alu_b) >>> alu_sa;
            endcase
         end
         SEL_SLT:   alu_out = ($signed(alu_a) < $signed(alu_b)) ? '1 : '0;
         SEL_ARITH: alu_out = (alu_arithop == ARITH_ADD) ? alu_a + alu_b : alu_a - alu_b;
         default: begin
            case (alu_logicop)
               2'd0:    alu_out = alu_a & alu_b;
               2'd1:    alu_out = alu_a | alu_b;
               2'd2:    alu_out = alu_a ^ alu_b;
               default: alu_out = ~(alu_a | alu_b);
            endcase
         end
      endcase
   end
   assign alu_zero = (alu_out == '0);

   task automatic clear_inputs();
      req_valid = 2'b00; rsp_ready = 2'b11;
      a0 = '0; a1 = '0; b0 = '0; b1 = '0; sa0 = '0; sa1 = '0; op0 = '0; op1 = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      clear_inputs();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      clear_inputs();
      req_valid = 2'b01;
      repeat (2) @(negedge clk);
      #1;
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready got=%b exp=00", req_ready); end
      checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=00", rsp_valid); end
      checks++; if (alu_a !== '0 || alu_b !== '0 || alu_sa !== '0 || alu_sel !== 2'd0 || alu_shiftop !== 2'd0 || alu_arithop !== 1'b0 || alu_logicop !== 2'd0)
         begin errors++; $display("FAIL reset_alu_bus got a=%h b=%h sel=%0d exp all zero", alu_a, alu_b, alu_sel); end
      checks++; if (rsp_data !== '0 || rsp_zero !== 1'b0) begin errors++; $display("FAIL reset_rsp got data=%h zero=%b exp 0/0", rsp_data, rsp_zero); end
      req_valid = 2'b00;
      rst_n = 1'b1;
   endtask

   task automatic test_add();
      @(negedge clk); req_valid = 2'b01; a0 = 32'd5; b0 = 32'd3; op0 = 7'b1000000; #1;
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL add_ready got=%b exp=01", req_ready); end
      @(negedge clk); req_valid = 2'b00; #1;
      checks++; if (req_ready !== 2'b00 || rsp_valid !== 2'b00) begin errors++; $display("FAIL add_exec_hs got ready=%b valid=%b exp 00/00", req_ready, rsp_valid); end
      checks++; if (alu_a !== 32'd5 || alu_b !== 32'd3 || alu_sel !== 2'd2 || alu_arithop !== 1'b0)
         begin errors++; $display("FAIL add_alu_bus got a=%0d b=%0d sel=%0d ar=%b exp 5/3/2/0", alu_a, alu_b, alu_sel, alu_arithop); end
      @(negedge clk); #1;
      checks++; if (rsp_valid !== 2'b01 || rsp_data !== 32'd8 || rsp_zero !== 1'b0)
         begin errors++; $display("FAIL add_rsp got valid=%b data=%h zero=%b exp 01/8/0", rsp_valid, rsp_data, rsp_zero); end
      @(negedge clk); #1;
      checks++; if (rsp_valid !== 2'b00 || rsp_data !== 32'd8 || alu_a !== 32'd5)
         begin errors++; $display("FAIL add_hold got valid=%b data=%h a=%h exp 00/8/5", rsp_valid, rsp_data, alu_a); end
   endtask

   task automatic test_tie();
      do_reset();
      @(negedge clk);
      req_valid = 2'b11; a0 = 32'd7; b0 = 32'd7; op0 = 7'b1000100;
      a1 = 32'hF0; b1 = 32'h0F; op1 = 7'b1100001; #1;
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL tie_first_grant got=%b exp=01", req_ready); end
      @(negedge clk); req_valid = 2'b10; #1;
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL tie_exec_ready got=%b exp=00", req_ready); end
      @(negedge clk); #1;
      checks++; if (rsp_valid !== 2'b01 || rsp_data !== 32'd0 || rsp_zero !== 1'b1 || req_ready !== 2'b00)
         begin errors++; $display("FAIL tie_sub_rsp got valid=%b data=%h zero=%b ready=%b exp 01/0/1/00", rsp_valid, rsp_data, rsp_zero, req_ready); end
      @(negedge clk); #1;
      checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL tie_second_grant got=%b exp=10", req_ready); end
      @(negedge clk); req_valid = 2'b00; #1;
      checks++; if (alu_sel !== 2'd3 || alu_logicop !== 2'd1) begin errors++; $display("FAIL tie_logic_bus got sel=%0d lop=%0d exp 3/1", alu_sel, alu_logicop); end
      @(negedge clk); #1;
      checks++; if (rsp_valid !== 2'b10 || rsp_data !== 32'hFF || rsp_zero !== 1'b0)
         begin errors++; $display("FAIL tie_logic_rsp got valid=%b data=%h zero=%b exp 10/ff/0", rsp_valid, rsp_data, rsp_zero); end
   endtask

   task automatic test_back_to_back();
      logic [1:0]   exp_oh;
      logic [W-1:0] exp_data;
      do_reset();
      @(negedge clk);
      a0 = 32'd1;  b0 = 32'd2;  op0 = 7'b1000000;
      a1 = 32'd10; b1 = 32'd20; op1 = 7'b1000000;
      req_valid = 2'b11; rsp_ready = 2'b11;
      for (int k = 0; k < 12; k++) begin
         if (k > 0) @(negedge clk);
         #1;
         exp_oh   = ((k / 3) % 2 == 1) ? 2'b10 : 2'b01;
         exp_data = ((k / 3) % 2 == 1) ? 32'd30 : 32'd3;
         checks++;
         if (req_ready !== ((k % 3 == 0) ? exp_oh : 2'b00))
            begin errors++; $display("FAIL b2b_ready cycle=%0d got=%b exp=%b", k, req_ready, (k % 3 == 0) ? exp_oh : 2'b00); end
         if (k % 3 == 2) begin
            checks++;
            if (rsp_valid !== exp_oh || rsp_data !== exp_data)
               begin errors++; $display("FAIL b2b_rsp cycle=%0d got valid=%b data=%h exp %b/%h", k, rsp_valid, rsp_data, exp_oh, exp_data); end
         end
      end
      @(negedge clk); req_valid = 2'b00;
   endtask

   task automatic test_rsp_hold();
      do_reset();
      @(negedge clk);
      req_valid = 2'b11; rsp_ready = 2'b10;
      a0 = 32'hFFFF_FFFF; b0 = 32'd1; sa0 = 5'd0;  op0 = 7'b0100100;
      a1 = 32'd0;         b1 = 32'd1; sa1 = 5'd31; op1 = 7'b0000000;
      #1;
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL hold_grant0 got=%b exp=01", req_ready); end
      @(negedge clk); req_valid = 2'b10; #1;
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL hold_exec_ready got=%b exp=00", req_ready); end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #1;
         checks++;
         if (rsp_valid !== 2'b01 || rsp_data !== 32'hFFFF_FFFF || rsp_zero !== 1'b0 || req_ready !== 2'b00)
            begin errors++; $display("FAIL hold_resp cycle=%0d got valid=%b data=%h zero=%b ready=%b exp 01/ffffffff/0/00", i, rsp_valid, rsp_data, rsp_zero, req_ready); end
      end
      @(negedge clk); rsp_ready = 2'b01; #1;
      checks++; if (rsp_valid !== 2'b01 || req_ready !== 2'b00) begin errors++; $display("FAIL hold_release got valid=%b ready=%b exp 01/00", rsp_valid, req_ready); end
      @(negedge clk); rsp_ready = 2'b11; #1;
      checks++; if (req_ready !== 2'b10 || rsp_valid !== 2'b00) begin errors++; $display("FAIL hold_grant1 got ready=%b valid=%b exp 10/00", req_ready, rsp_valid); end
      @(negedge clk); req_valid = 2'b00; #1;
      checks++; if (alu_sa !== 5'd31 || alu_sel !== 2'd0) begin errors++; $display("FAIL hold_shift_bus got sa=%0d sel=%0d exp 31/0", alu_sa, alu_sel); end
      @(negedge clk); #1;
      checks++; if (rsp_valid !== 2'b10 || rsp_data !== 32'h8000_0000 || rsp_zero !== 1'b0)
         begin errors++; $display("FAIL hold_shift_rsp got valid=%b data=%h zero=%b exp 10/80000000/0", rsp_valid, rsp_data, rsp_zero); end
   endtask

   task automatic test_reset_exec();
      do_reset();
      @(negedge clk); req_valid = 2'b01; a0 = 32'h1234; b0 = 32'd1; op0 = 7'b1000000; rsp_ready = 2'b11; #1;
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rstx_grant got=%b exp=01", req_ready); end
      @(negedge clk); #1;
      checks++; if (alu_a !== 32'h1234) begin errors++; $display("FAIL rstx_exec_a got=%h exp=1234", alu_a); end
      rst_n = 1'b0; #1;
      checks++; if (alu_a !== '0 || alu_b !== '0 || alu_sel !== 2'd0 || rsp_data !== '0 || rsp_valid !== 2'b00 || req_ready !== 2'b00)
         begin errors++; $display("FAIL rstx_async got a=%h b=%h sel=%0d data=%h valid=%b ready=%b exp all zero", alu_a, alu_b, alu_sel, rsp_data, rsp_valid, req_ready); end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); #1;
         checks++; if (rsp_valid !== 2'b00 || req_ready !== 2'b00) begin errors++; $display("FAIL rstx_in_reset cycle=%0d got valid=%b ready=%b exp 00/00", i, rsp_valid, req_ready); end
      end
      @(negedge clk); rst_n = 1'b1; req_valid = 2'b10; a1 = 32'd40; b1 = 32'd2; op1 = 7'b1000100; #1;
      checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL rstx_req1_grant got=%b exp=10", req_ready); end
      @(negedge clk); req_valid = 2'b00; #1;
      checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rstx_no_stale_rsp got=%b exp=00", rsp_valid); end
      @(negedge clk); #1;
      checks++; if (rsp_valid !== 2'b10 || rsp_data !== 32'd38 || rsp_zero !== 1'b0)
         begin errors++; $display("FAIL rstx_req1_rsp got valid=%b data=%h zero=%b exp 10/26/0", rsp_valid, rsp_data, rsp_zero); end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_add();
      test_tie();
      test_back_to_back();
      test_rsp_hold();
      test_reset_exec();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout simulation did not complete got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter and sequencer for the shared 32-bit execute ALU (shifter / set-less-than / add-sub / logic unit with zero flag). Each requester presents operands plus an ALU control word under a valid/ready handshake. The block grants the ALU round-robin, drives its inputs from registers for one execute cycle, and captures the result and zero flag. It then returns the result to the granted requester under a second valid/ready handshake. It sits between the EX-stage issue logic and the single ALU instance.

## Interface
- W, 32, operand/result width
- SAW, 5, shift-amount width
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_req_valid[1:0]  in  2  request valid per requester
- o_req_ready[1:0]  out  2  request accepted this cycle (one-hot or zero)
- i_req_a0 / i_req_a1  in  W  operand A per requester
- i_req_b0 / i_req_b1  in  W  operand B per requester
- i_req_sa0 / i_req_sa1  in  SAW  shift amount per requester
- i_req_op0 / i_req_op1  in  7  control {sel[6:5], shift[4:3], arith[2], logic[1:0]}
- o_alu_a, o_alu_b  out  W  ALU operands
- o_alu_sa  out  SAW  ALU shift amount
- o_alu_shiftop  out  2;  o_alu_arithop  out  1;  o_alu_logicop  out  2;  o_alu_sel  out  2  (sel: 0 shift, 1 slt, 2 add/sub, 3 logic; arith: 0 add, 1 sub)
- i_alu_out  in  W  ALU result
- i_alu_zero  in  1  ALU zero flag (result == 0)
- o_rsp_valid[1:0]  out  2  response valid per requester (one-hot or zero)
- i_rsp_ready[1:0]  in  2  response accepted per requester
- o_rsp_data  out  W  result, shared by both requesters
- o_rsp_zero  out  1  zero flag, shared by both requesters

## Operation
- FSM states: IDLE -> EXEC -> RESP -> IDLE.
- IDLE: arbitrate. Only one requester valid -> grant it. Both valid -> grant the one not granted last (rr_last).
  - o_req_ready[g] = 1 combinationally for the granted requester only.
  - On the handshake, register the requester's A, B, SA and op into the ALU-drive registers, record g, go to EXEC.
- EXEC: ALU inputs come from the registers. At the end of the cycle, capture i_alu_out and i_alu_zero into o_rsp_data / o_rsp_zero, then go to RESP.
- RESP: o_rsp_valid[g] = 1. On i_rsp_ready[g], set rr_last = g and go to IDLE. i_rsp_ready of the non-granted requester is ignored.
- o_req_ready is 0 outside IDLE. Only one operation is in flight; there is no overlap between RESP and a new accept.
- ALU-drive registers hold their last values outside EXEC. o_rsp_data / o_rsp_zero hold until the next capture.
- Requesters keep valid and payload stable until ready. The arbiter re-evaluates every IDLE cycle.
- No width conversion. Results pass through unmodified, including the slt all-ones/all-zeros bus.

## Timing
- Reset (async assert, sync release): state = IDLE; rr_last = 1, so requester 0 wins the first tie. All o_alu_* = 0; o_rsp_data = 0; o_rsp_zero = 0; o_rsp_valid = 0; o_req_ready = 0 while reset is asserted.
- Request accepted at edge N -> EXEC in cycle N+1 -> o_rsp_valid high from cycle N+2.
- Minimum issue interval is 3 cycles, with i_rsp_ready held high.
- i_rsp_ready low: stay in RESP indefinitely. Data stays stable and no new grant is issued.
- Reset mid-EXEC or mid-RESP: the operation is discarded, no response is produced, and the next grant after reset starts from requester 0.
- Both valid with rr_last = 0 -> grant 1; with rr_last = 1 -> grant 0.
- A requester that keeps valid high through its own RESP is not re-granted ahead of a waiting peer.

## Structure
- Package alu_arb_pkg holds:
  - state enum {IDLE, EXEC, RESP}
  - op-word field positions
  - ALU select constants SEL_SHIFT=0, SEL_SLT=1, SEL_ARITH=2, SEL_LOGIC=3; ARITH_ADD=0, ARITH_SUB=1
- Sub-module rr_arbiter2 contains the 2-way round-robin grant logic (inputs valid[1:0] and rr_last; output grant one-hot). The FSM and datapath registers stay in alu_arbiter.

## Test plan
- Reset, then req0 only: A=5, B=3, op sel=2 arith=0 -> ready0 in cycle 0; rsp_valid0 in cycle 2 with data=8, zero=0.
- Both valid after reset: req0 sub 7-7, req1 logic op -> req0 granted first (data=0, zero=1); req1 granted in the next IDLE.
- Back-to-back ties, both valid continuously -> grants alternate 0,1,0,1; interval exactly 3 cycles with rsp_ready high.
- rsp_ready0 held low 5 cycles while req1 valid -> RESP held, data stable, ready1 stays 0; req1 granted on the cycle after the release.
- slt A=-1, B=1 (sel=1, arith=1) -> data=32'hFFFFFFFF, zero=0; shift B=1, SA=31 -> data=32'h80000000.
- Assert i_rst_n low during EXEC -> all outputs reset asynchronously, no rsp_valid; after release, req1 alone is granted normally.
